// File: rtl/fpu_bus_if_pkg.sv
// Shared types and constants for the Sol-1 byte bus front end of the fpu core.
package pa_fpu;

    typedef enum logic [3:0] {
        FPU_OP_ADD          = 4'd0,
        FPU_OP_SUB          = 4'd1,
        FPU_OP_MUL          = 4'd2,
        FPU_OP_DIV          = 4'd3,
        FPU_OP_SQRT         = 4'd4,
        FPU_OP_INT_TO_FLOAT = 4'd5,
        FPU_OP_FLOAT_TO_INT = 4'd6
    } e_fpu_op;

    localparam e_fpu_op FPU_OP_LAST = FPU_OP_FLOAT_TO_INT;

    localparam logic [3:0] FPU_REG_A0     = 4'h0;
    localparam logic [3:0] FPU_REG_B0     = 4'h4;
    localparam logic [3:0] FPU_REG_CMD    = 4'h8;
    localparam logic [3:0] FPU_REG_STATUS = 4'h9;
    localparam logic [3:0] FPU_REG_CTRL   = 4'hA;
    localparam logic [3:0] FPU_REG_RES0   = 4'hC;

    localparam int STS_BUSY    = 0;
    localparam int STS_DONE    = 1;
    localparam int STS_OVERRUN = 2;
    localparam int STS_TIMEOUT = 3;
    localparam int STS_BAD_OP  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } e_fpu_if_state;

endpackage

// File: rtl/fpu_bus_if_if.sv
// Byte-wide CPU register bus; the CPU side is the master, the front end the slave.
interface fpu_bus_if_if #(
    parameter int ADDR_W = 4
);
    logic              cs;
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic [7:0]        rdata;

    modport master (output cs, wr, rd, addr, wdata, input rdata);
    modport slave  (input cs, wr, rd, addr, wdata, output rdata);
endinterface

// File: rtl/fpu_bus_if_regs.sv
// Byte-lane register file for the fpu front end: operands, result, status/ctrl, read mux.
module fpu_bus_regs
    import pa_fpu::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic        clk,
    input  logic        arst_n,
    fpu_bus_if_if.slave bus,
    input  logic        busy,
    input  logic        set_done,
    input  logic        set_timeout,
    input  logic [31:0] result_in,
    output logic [31:0] reg_a,
    output logic [31:0] reg_b,
    output logic        cmd_go,
    output logic [3:0]  cmd_op,
    output logic        done,
    output logic        irq_en
);

    logic [31:0] reg_res;
    logic        overrun, timeout, bad_op;
    logic [3:0]  sel;
    logic        mapped, wr_en, rd_en, op_wr, cmd_wr, op_legal;
    logic [7:0]  w1c, rd_mux;

    assign sel      = bus.addr[3:0];
    assign mapped   = (bus.addr >> 4) == ADDR_W'(0);
    assign wr_en    = bus.cs & bus.wr & mapped;
    assign rd_en    = bus.cs & bus.rd;
    assign op_wr    = wr_en & (sel <= FPU_REG_CMD);
    assign cmd_wr   = wr_en & ~busy & (sel == FPU_REG_CMD);
    assign op_legal = bus.wdata[3:0] <= 4'(FPU_OP_LAST);
    assign cmd_go   = cmd_wr & op_legal;
    assign cmd_op   = bus.wdata[3:0];
    assign w1c      = (wr_en && sel == FPU_REG_STATUS) ? bus.wdata : 8'h00;

    always_comb begin
        rd_mux = 8'h00;
        if (mapped) begin
            case (sel)
                4'h0, 4'h1, 4'h2, 4'h3: rd_mux = reg_a[8*sel[1:0] +: 8];
                4'h4, 4'h5, 4'h6, 4'h7: rd_mux = reg_b[8*sel[1:0] +: 8];
                FPU_REG_STATUS:         rd_mux = {3'b000, bad_op, timeout, overrun, done, busy};
                FPU_REG_CTRL:           rd_mux = {7'b0, irq_en};
                4'hC, 4'hD, 4'hE, 4'hF: rd_mux = reg_res[8*sel[1:0] +: 8];
                default:                rd_mux = 8'h00;
            endcase
        end
    end

    // Set events take priority over a W1C landing in the same cycle.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            reg_a     <= '0;
            reg_b     <= '0;
            reg_res   <= '0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            timeout   <= 1'b0;
            bad_op    <= 1'b0;
            irq_en    <= 1'b0;
            bus.rdata <= 8'h00;
        end else begin
            if (wr_en && !busy && sel[3:2] == 2'b00) reg_a[8*sel[1:0] +: 8] <= bus.wdata;
            if (wr_en && !busy && sel[3:2] == 2'b01) reg_b[8*sel[1:0] +: 8] <= bus.wdata;
            if (set_done) reg_res <= result_in;
            if (wr_en && sel == FPU_REG_CTRL) irq_en <= bus.wdata[0];
            done    <= set_done    | (done    & ~cmd_go & ~w1c[STS_DONE]);
            timeout <= set_timeout | (timeout & ~cmd_go & ~w1c[STS_TIMEOUT]);
            overrun <= (op_wr & busy)           | (overrun & ~w1c[STS_OVERRUN]);
            bad_op  <= (cmd_wr & ~op_legal)     | (bad_op  & ~w1c[STS_BAD_OP]);
            if (rd_en) bus.rdata <= rd_mux;
        end
    end

endmodule

// File: rtl/fpu_bus_if.sv
// Sol-1 bus front end for the fpu core: command FSM, start/cmd_end handshake and watchdog.
module fpu_bus_if
    import pa_fpu::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ADDR_W         = 4
) (
    input  logic        clk,
    input  logic        arst_n,
    fpu_bus_if_if.slave bus,
    output logic        irq,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output e_fpu_op     fpu_op,
    output logic        fpu_start,
    input  logic [31:0] fpu_result,
    input  logic        fpu_cmd_end,
    input  logic        fpu_busy
);

    e_fpu_if_state state, state_nx;
    logic [15:0]   wdog;
    logic          busy, set_done, set_timeout, cmd_go, done, irq_en;
    logic [3:0]    cmd_op;

    assign busy      = state != IDLE;
    assign fpu_start = (state == ISSUE) || (state == WAIT);
    assign irq       = done & irq_en;

    fpu_bus_regs #(.ADDR_W(ADDR_W)) u_regs (
        .clk         (clk),
        .arst_n      (arst_n),
        .bus         (bus),
        .busy        (busy),
        .set_done    (set_done),
        .set_timeout (set_timeout),
        .result_in   (fpu_result),
        .reg_a       (fpu_a),
        .reg_b       (fpu_b),
        .cmd_go      (cmd_go),
        .cmd_op      (cmd_op),
        .done        (done),
        .irq_en      (irq_en)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else         state <= state_nx;
    end

    // Watchdog loads TIMEOUT_CYCLES-1 so start stays high exactly TIMEOUT_CYCLES cycles.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wdog   <= '0;
            fpu_op <= FPU_OP_ADD;
        end else if (cmd_go) begin
            wdog   <= 16'(TIMEOUT_CYCLES - 1);
            fpu_op <= e_fpu_op'(cmd_op);
        end else if (fpu_start && wdog != '0) begin
            wdog <= wdog - 16'd1;
        end
    end

    always_comb begin
        state_nx    = state;
        set_done    = 1'b0;
        set_timeout = 1'b0;
        case (state)
            IDLE:  if (cmd_go) state_nx = ISSUE;
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (fpu_cmd_end) begin
                    set_done = 1'b1;
                    state_nx = DRAIN;
                end else if (wdog == '0) begin
                    set_timeout = 1'b1;
                    state_nx    = DRAIN;
                end
            end
            DRAIN: if (!fpu_cmd_end && !fpu_busy) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

endmodule
